// File: rtl/seg_scan_decoder.sv
// Recovers a four-digit MM:SS value from a scanned, active-low 7-segment bus.
// Digits are debounced, checked for scan order, and committed a full frame at a time.
module seg_scan_decoder #(
  parameter int STABLE = 1
) (
  input  logic       clk_m,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [7:0] seg,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       frame_done,
  output logic       frame_valid,
  output logic       seq_err,
  output logic       code_err,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] STAB = 4'(STABLE);
  localparam logic [3:0] AN_MT = 4'b0111;
  localparam logic [3:0] AN_MO = 4'b1011;
  localparam logic [3:0] AN_ST = 4'b1101;
  localparam logic [3:0] AN_SO = 4'b1110;

  typedef enum logic [1:0] {HUNT, GOT3, GOT2, GOT1} state_t;

  // Returns {illegal, digit}.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = 5'd0;
      7'h79:   decode = 5'd1;
      7'h24:   decode = 5'd2;
      7'h30:   decode = 5'd3;
      7'h19:   decode = 5'd4;
      7'h12:   decode = 5'd5;
      7'h02:   decode = 5'd6;
      7'h78:   decode = 5'd7;
      7'h00:   decode = 5'd8;
      7'h10:   decode = 5'd9;
      default: decode = 5'h10;
    endcase
  endfunction

  logic [3:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;
  logic [3:0] stab_cnt_q, stab_cnt_d;
  logic       acc_done_q, acc_done_d;
  state_t     state_q, state_d;
  logic [3:0] sh_mt_q, sh_mt_d, sh_mo_q, sh_mo_d, sh_st_q, sh_st_d;
  logic [3:0] min_tens_q, min_tens_d, min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
  logic       frame_done_q, frame_done_d, frame_valid_q, frame_valid_d;
  logic       seq_err_q, seq_err_d, code_err_q, code_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       differ, an_legal, accept;
  logic [4:0] dec;

  always_comb begin
    differ     = ({an, seg} != {an_q, seg_q});
    an_legal   = (an_q == AN_MT) || (an_q == AN_MO) || (an_q == AN_ST) || (an_q == AN_SO);
    // acc_done_q keeps a saturated run from being accepted a second time.
    accept     = an_legal && (stab_cnt_q == STAB) && !acc_done_q;
    dec        = decode(seg_q[6:0]);

    an_d       = an;
    seg_d      = seg;
    stab_cnt_d = differ ? 4'd1 : ((stab_cnt_q >= STAB) ? STAB : stab_cnt_q + 4'd1);
    acc_done_d = differ ? 1'b0 : (acc_done_q | accept);

    state_d       = state_q;
    sh_mt_d       = sh_mt_q;
    sh_mo_d       = sh_mo_q;
    sh_st_d       = sh_st_q;
    min_tens_d    = min_tens_q;
    min_ones_d    = min_ones_q;
    sec_tens_d    = sec_tens_q;
    sec_ones_d    = sec_ones_q;
    frame_done_d  = 1'b0;
    frame_valid_d = frame_valid_q;
    seq_err_d     = 1'b0;
    code_err_d    = 1'b0;

    if (accept) begin
      if (dec[4]) begin
        code_err_d = 1'b1;
        state_d    = HUNT;
      end else if (an_q == AN_MT) begin
        sh_mt_d = dec[3:0];
        state_d = GOT3;
      end else if (state_q == GOT3 && an_q == AN_MO) begin
        sh_mo_d = dec[3:0];
        state_d = GOT2;
      end else if (state_q == GOT2 && an_q == AN_ST) begin
        sh_st_d = dec[3:0];
        state_d = GOT1;
      end else if (state_q == GOT1 && an_q == AN_SO) begin
        min_tens_d    = sh_mt_q;
        min_ones_d    = sh_mo_q;
        sec_tens_d    = sh_st_q;
        sec_ones_d    = dec[3:0];
        frame_done_d  = 1'b1;
        frame_valid_d = 1'b1;
        state_d       = HUNT;
      end else begin
        seq_err_d = 1'b1;
        state_d   = HUNT;
      end
    end

    err_cnt_d = err_cnt_q;
    if ((seq_err_d || code_err_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_m) begin
    if (!rst_n) begin
      an_q          <= 4'hF;
      seg_q         <= 8'hFF;
      stab_cnt_q    <= 4'd0;
      acc_done_q    <= 1'b0;
      state_q       <= HUNT;
      sh_mt_q       <= 4'd0;
      sh_mo_q       <= 4'd0;
      sh_st_q       <= 4'd0;
      min_tens_q    <= 4'd0;
      min_ones_q    <= 4'd0;
      sec_tens_q    <= 4'd0;
      sec_ones_q    <= 4'd0;
      frame_done_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
      code_err_q    <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      an_q          <= an_d;
      seg_q         <= seg_d;
      stab_cnt_q    <= stab_cnt_d;
      acc_done_q    <= acc_done_d;
      state_q       <= state_d;
      sh_mt_q       <= sh_mt_d;
      sh_mo_q       <= sh_mo_d;
      sh_st_q       <= sh_st_d;
      min_tens_q    <= min_tens_d;
      min_ones_q    <= min_ones_d;
      sec_tens_q    <= sec_tens_d;
      sec_ones_q    <= sec_ones_d;
      frame_done_q  <= frame_done_d;
      frame_valid_q <= frame_valid_d;
      seq_err_q     <= seq_err_d;
      code_err_q    <= code_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign min_tens    = min_tens_q;
  assign min_ones    = min_ones_q;
  assign sec_tens    = sec_tens_q;
  assign sec_ones    = sec_ones_q;
  assign frame_done  = frame_done_q;
  assign frame_valid = frame_valid_q;
  assign seq_err     = seq_err_q;
  assign code_err    = code_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: one instance at STABLE=1, one at STABLE=3.
module tb_seg_scan_decoder;

  logic       clk_m = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] an1 = 4'hF, an3 = 4'hF;
  logic [7:0] seg1 = 8'hFF, seg3 = 8'hFF;

  logic [3:0] mt1, mo1, st1, so1, mt3, mo3, st3, so3;
  logic       fd1, fv1, se1, ce1, fd3, fv3, se3, ce3;
  logic [7:0] ec1, ec3;

  int checks = 0;
  int failures = 0;

  always #5 clk_m = ~clk_m;

  seg_scan_decoder #(.STABLE(1)) dut1 (
    .clk_m(clk_m), .rst_n(rst_n), .an(an1), .seg(seg1),
    .min_tens(mt1), .min_ones(mo1), .sec_tens(st1), .sec_ones(so1),
    .frame_done(fd1), .frame_valid(fv1), .seq_err(se1), .code_err(ce1), .err_cnt(ec1)
  );

  seg_scan_decoder #(.STABLE(3)) dut3 (
    .clk_m(clk_m), .rst_n(rst_n), .an(an3), .seg(seg3),
    .min_tens(mt3), .min_ones(mo3), .sec_tens(st3), .sec_ones(so3),
    .frame_done(fd3), .frame_valid(fv3), .seq_err(se3), .code_err(ce3), .err_cnt(ec3)
  );

  task automatic step();
    @(posedge clk_m);
    #1;
  endtask

  task automatic drv1(input logic [3:0] a, input logic [7:0] s);
    an1 = a;
    seg1 = s;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    an1 = 4'b0111; seg1 = 8'hC0;
    an3 = 4'b0111; seg3 = 8'hC0;
    step();
    step();
    checks++; if ({mt1, mo1, st1, so1} !== 16'h0) begin failures++; $display("FAIL reset_digits1 got=%h exp=0000", {mt1, mo1, st1, so1}); end
    checks++; if ({fd1, fv1, se1, ce1} !== 4'b0) begin failures++; $display("FAIL reset_flags1 got=%b exp=0000", {fd1, fv1, se1, ce1}); end
    checks++; if (ec1 !== 8'd0) begin failures++; $display("FAIL reset_errcnt1 got=%0d exp=0", ec1); end
    checks++; if ({mt3, mo3, st3, so3, fd3, fv3, se3, ce3, ec3} !== 28'h0) begin failures++; $display("FAIL reset_all3 got=%h exp=0", {mt3, mo3, st3, so3, fd3, fv3, se3, ce3, ec3}); end
    an1 = 4'hF; seg1 = 8'hFF;
    an3 = 4'hF; seg3 = 8'hFF;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_rotate();
    drv1(4'b0111, 8'hC0);
    checks++; if (fd1 !== 1'b0) begin failures++; $display("FAIL rotate_early_fd got=%b exp=0", fd1); end
    drv1(4'b1011, 8'hA4);
    drv1(4'b1101, 8'h99);
    drv1(4'b1110, 8'h90);
    checks++; if ({fd1, fv1, mo1, st1, so1} !== 14'h0) begin failures++; $display("FAIL rotate_partial got=%h exp=0", {fd1, fv1, mo1, st1, so1}); end
    drv1(4'hF, 8'hFF);
    checks++; if (fd1 !== 1'b1) begin failures++; $display("FAIL rotate_fd got=%b exp=1", fd1); end
    checks++; if ({mt1, mo1, st1, so1} !== 16'h0249) begin failures++; $display("FAIL rotate_digits got=%h exp=0249", {mt1, mo1, st1, so1}); end
    drv1(4'hF, 8'hFF);
    checks++; if ({fd1, fv1} !== 2'b01) begin failures++; $display("FAIL rotate_pulse_sticky got=%b exp=01", {fd1, fv1}); end
  endtask

  task automatic test_back_to_back();
    drv1(4'b0111, 8'h80);
    drv1(4'b1011, 8'h82);
    drv1(4'b1101, 8'hF9);
    drv1(4'b1110, 8'hA4);
    drv1(4'b0111, 8'hB0);
    checks++; if ({fd1, mt1, mo1, st1, so1} !== 17'h18612) begin failures++; $display("FAIL b2b_first got=%h exp=18612", {fd1, mt1, mo1, st1, so1}); end
    drv1(4'b1011, 8'h90);
    checks++; if (fd1 !== 1'b0) begin failures++; $display("FAIL b2b_pulse got=%b exp=0", fd1); end
    drv1(4'b1101, 8'hF8);
    drv1(4'b1110, 8'h40);
    drv1(4'b0111, 8'h80);
    checks++; if ({fd1, mt1, mo1, st1, so1} !== 17'h13970) begin failures++; $display("FAIL b2b_second got=%h exp=13970", {fd1, mt1, mo1, st1, so1}); end
    drv1(4'hF, 8'hFF);
  endtask

  task automatic test_seq_err();
    drv1(4'b0111, 8'hC0);
    drv1(4'b1011, 8'hF9);
    drv1(4'b1110, 8'h90);
    drv1(4'hF, 8'hFF);
    checks++; if ({se1, ce1, fd1} !== 3'b100) begin failures++; $display("FAIL seq_pulse got=%b exp=100", {se1, ce1, fd1}); end
    checks++; if (ec1 !== 8'd1) begin failures++; $display("FAIL seq_errcnt got=%0d exp=1", ec1); end
    checks++; if ({mt1, mo1, st1, so1} !== 16'h3970) begin failures++; $display("FAIL seq_hold got=%h exp=3970", {mt1, mo1, st1, so1}); end
    drv1(4'b0111, 8'hF9);
    checks++; if (se1 !== 1'b0) begin failures++; $display("FAIL seq_one_cycle got=%b exp=0", se1); end
    drv1(4'b1011, 8'hB0);
    drv1(4'b1101, 8'h92);
    drv1(4'b1110, 8'hF8);
    drv1(4'hF, 8'hFF);
    checks++; if ({fd1, mt1, mo1, st1, so1} !== 17'h11357) begin failures++; $display("FAIL seq_recover got=%h exp=11357", {fd1, mt1, mo1, st1, so1}); end
  endtask

  task automatic test_code_err();
    drv1(4'b0111, 8'hC0);
    drv1(4'b1011, 8'hA4);
    drv1(4'b1101, 8'hFF);
    drv1(4'hF, 8'hFF);
    checks++; if ({ce1, se1, fd1} !== 3'b100) begin failures++; $display("FAIL code_pulse got=%b exp=100", {ce1, se1, fd1}); end
    checks++; if ({ec1, mt1, mo1, st1, so1} !== 24'h021357) begin failures++; $display("FAIL code_state got=%h exp=021357", {ec1, mt1, mo1, st1, so1}); end
    drv1(4'b0111, 8'hFF);
    drv1(4'b1011, 8'hA4);
    checks++; if ({ce1, se1} !== 2'b10) begin failures++; $display("FAIL code_mt got=%b exp=10", {ce1, se1}); end
    drv1(4'hF, 8'hFF);
    checks++; if ({ce1, se1, ec1} !== 10'h104) begin failures++; $display("FAIL code_mt_hunt got=%h exp=104", {ce1, se1, ec1}); end
    drv1(4'b1110, 8'hFF);
    drv1(4'hF, 8'hFF);
    checks++; if ({ce1, se1, ec1} !== 10'h205) begin failures++; $display("FAIL code_priority got=%h exp=205", {ce1, se1, ec1}); end
  endtask

  task automatic test_blanks();
    logic [3:0] ta [8] = '{4'b0111, 4'hF, 4'b1011, 4'hF, 4'b1101, 4'hF, 4'b1110, 4'hF};
    logic [7:0] ts [8] = '{8'h92, 8'hFF, 8'h90, 8'hFF, 8'hC0, 8'hFF, 8'hB0, 8'hFF};
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      drv1(ta[i], ts[i]);
      if (se1 || ce1 || (i < 7 && fd1)) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL blanks_spurious got=%0d exp=0", bad); end
    checks++; if ({fd1, mt1, mo1, st1, so1, ec1} !== 25'h1590305) begin failures++; $display("FAIL blanks_commit got=%h exp=1590305", {fd1, mt1, mo1, st1, so1, ec1}); end
  endtask

  task automatic test_reset_mid();
    int fdn = 0;
    drv1(4'b0111, 8'hC0);
    drv1(4'b1011, 8'hA4);
    drv1(4'hF, 8'hFF);
    rst_n = 1'b0;
    drv1(4'hF, 8'hFF);
    checks++; if ({mt1, mo1, st1, so1, fd1, fv1, se1, ce1, ec1} !== 28'h0) begin failures++; $display("FAIL rstmid_clear got=%h exp=0", {mt1, mo1, st1, so1, fd1, fv1, se1, ce1, ec1}); end
    rst_n = 1'b1;
    drv1(4'b1101, 8'h99);
    fdn += int'(fd1);
    drv1(4'b1110, 8'h90);
    fdn += int'(fd1);
    checks++; if (se1 !== 1'b1) begin failures++; $display("FAIL rstmid_seq_st got=%b exp=1", se1); end
    drv1(4'hF, 8'hFF);
    fdn += int'(fd1);
    checks++; if (se1 !== 1'b1) begin failures++; $display("FAIL rstmid_seq_so got=%b exp=1", se1); end
    drv1(4'hF, 8'hFF);
    fdn += int'(fd1);
    checks++; if (fdn !== 0 || {fv1, mt1, mo1, st1, so1} !== 17'h0 || ec1 !== 8'd2) begin failures++; $display("FAIL rstmid_nocommit got=fd%0d fv%b d%h ec%0d exp=fd0 fv0 d0000 ec2", fdn, fv1, {mt1, mo1, st1, so1}, ec1); end
  endtask

  task automatic test_stable3();
    logic [3:0] ta [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [7:0] s2 [4] = '{8'hC0, 8'hA4, 8'h99, 8'h90};
    logic [7:0] s3 [4] = '{8'hF9, 8'hB0, 8'h92, 8'hF8};
    int ev = 0;
    for (int d = 0; d < 4; d++) begin
      an3 = ta[d]; seg3 = s2[d];
      for (int k = 0; k < 2; k++) begin step(); ev += int'(fd3) + int'(se3) + int'(ce3); end
    end
    an3 = 4'hF; seg3 = 8'hFF;
    for (int k = 0; k < 4; k++) begin step(); ev += int'(fd3) + int'(se3) + int'(ce3); end
    checks++; if (ev !== 0 || fv3 !== 1'b0) begin failures++; $display("FAIL s3_hold2 got=ev%0d fv%b exp=ev0 fv0", ev, fv3); end
    for (int d = 0; d < 3; d++) begin
      an3 = ta[d]; seg3 = s3[d];
      for (int k = 0; k < 3; k++) begin step(); ev += int'(fd3) + int'(se3) + int'(ce3); end
    end
    an3 = ta[3]; seg3 = s3[3];
    for (int k = 0; k < 3; k++) begin step(); ev += int'(fd3) + int'(se3) + int'(ce3); end
    checks++; if (ev !== 0) begin failures++; $display("FAIL s3_early got=%0d exp=0", ev); end
    an3 = 4'hF; seg3 = 8'hFF;
    step();
    checks++; if ({fd3, fv3, mt3, mo3, st3, so3} !== 18'h31357) begin failures++; $display("FAIL s3_commit got=%h exp=31357", {fd3, fv3, mt3, mo3, st3, so3}); end
  endtask

  task automatic test_saturate();
    rst_n = 1'b0;
    drv1(4'hF, 8'hFF);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) drv1(4'b1011, 8'hA4);
      else            drv1(4'b1101, 8'h99);
      if (i == 10) begin
        checks++; if (ec1 !== 8'd10) begin failures++; $display("FAIL sat_mid got=%0d exp=10", ec1); end
      end
    end
    drv1(4'hF, 8'hFF);
    checks++; if (ec1 !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", ec1); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_back_to_back();
    test_seq_err();
    test_code_err();
    test_blanks();
    test_reset_mid();
    test_stable3();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter: STABLE, default 1, number of consecutive identical {an,seg} samples needed before a digit is accepted; legal range 1..15.
REQ-002 clk_m  input  1  single system clock; all state SHALL change only on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low; it SHALL take effect only on a rising clk_m edge while low.
REQ-004 an  input  4  multiplexed digit enables, active-low one-hot: 0111=min_tens, 1011=min_ones, 1101=sec_tens, 1110=sec_ones.
REQ-005 seg  input  8  active-low segment pattern; seg[7]=dp and SHALL be ignored, seg[6:0] is decoded.
REQ-006 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD digits of the last complete, error-free frame.
REQ-007 frame_done  output  1  one-cycle pulse when the digit outputs update.
REQ-008 frame_valid  output  1  sticky, high once any good frame has been committed.
REQ-009 seq_err, code_err  output  1 each  one-cycle error pulses.
REQ-010 err_cnt  output  8  saturating count of seq_err plus code_err events.

Function
REQ-011 Input stage: an_q/seg_q SHALL register an/seg on every edge; stab_cnt SHALL go to 1 when the new sample differs from {an_q,seg_q}, else increment, saturating at STABLE.
REQ-012 Accept event: exactly one per stable run, on the edge where stab_cnt==STABLE and an_q is a legal one-hot-low value; the run is not re-accepted until {an,seg} changes.
REQ-013 an_q of 1111 (blank) or with two or more zeros SHALL produce no accept and no error.
REQ-014 Decode seg_q[6:0] as: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9 (hex); any other pattern is illegal.
REQ-015 FSM states: HUNT, GOT3, GOT2, GOT1, where expected digit is min_tens in HUNT, min_ones in GOT3, sec_tens in GOT2, and sec_ones in GOT1.
REQ-016 Accept of min_tens with a legal code in any state SHALL store the shadow digit and go to GOT3 without error; this is the resync point.
REQ-017 Accept of the expected digit with a legal code SHALL store the shadow digit and advance the state.
REQ-018 Accept of sec_ones in GOT1 with a legal code SHALL, on the same edge, load all four outputs from the shadow digits plus this digit, pulse frame_done, set frame_valid, and return to HUNT.
REQ-019 Accept of an unexpected non-min_tens digit SHALL pulse seq_err and go to HUNT; shadow digits are discarded and outputs are unchanged.
REQ-020 Accept with an illegal code SHALL pulse code_err and go to HUNT; if an_q=min_tens, it SHALL still go to HUNT, not GOT3.
REQ-021 seq_err and code_err SHALL never assert on the same edge; code_err has priority.
REQ-022 err_cnt SHALL increment on each error pulse and hold at 255.
REQ-023 Latency: the commit edge SHALL be STABLE edges after the first edge that samples the sec_ones pattern.
REQ-024 Outputs SHALL change only on commit edges (REQ-018); partial frames never reach the outputs.
REQ-025 Input rotation SHALL be accepted at one digit per clk_m cycle when STABLE=1.

Reset
REQ-026 While rst_n=0 at an edge: all digit outputs 0, frame_done 0, frame_valid 0, seq_err 0, code_err 0, err_cnt 0, an_q 1111, seg_q FF, stab_cnt 0, state HUNT.
REQ-027 Reset mid-frame SHALL discard the shadow digits; the first post-reset commit requires a full min_tens..sec_ones sequence.
REQ-028 The first edge with rst_n=1 SHALL sample inputs normally.

Verification
REQ-029 STABLE=1, rotate 0111/C0, 1011/A4, 1101/99, 1110/90 one per cycle -> frame_done 1 edge after the sec_ones sample, digits 0,2,4,9, frame_valid=1.
REQ-030 STABLE=3, hold each digit 2 cycles -> no accepts, no frame_done; hold each 3 cycles -> commit occurs 3 edges after the first sec_ones sample.
REQ-031 Sequence 0111, 1011, 1110 -> seq_err pulse, err_cnt=1, outputs unchanged; the next full ordered frame commits.
REQ-032 1101 with seg=FF (illegal) in GOT2 -> code_err, HUNT; an=1111 blanks interleaved in a good frame -> no error, frame commits.
REQ-033 rst_n low for one edge while in GOT2 -> all outputs 0; a subsequent sec_tens/sec_ones-only sequence gives seq_err and no commit.
REQ-034 Force 300 errors -> err_cnt saturates at 255.
